// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes and FSM states.
package mem_pkg;

  // DSize encodings; 2'b11 is handled as a word access wherever size is decoded.
  localparam logic [1:0] DSZ_BYTE = 2'b00;
  localparam logic [1:0] DSZ_HALF = 2'b01;
  localparam logic [1:0] DSZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects the addressed byte/half lane of a big-endian
// read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [0:31] rdata,
  input  logic [0:1]  a,
  input  logic [0:1]  DSize,
  input  logic        loadSign,
  output logic [0:31] result
);

  logic [0:7]  b;
  logic [0:15] h;

  // Lane select, then extend; bit 0 is the MSB so it is the sign bit.
  always_comb begin
    case (a)
      2'b00:   b = rdata[0:7];
      2'b01:   b = rdata[8:15];
      2'b10:   b = rdata[16:23];
      default: b = rdata[24:31];
    endcase
    h = a[0] ? rdata[16:31] : rdata[0:15];
    case (DSize)
      DSZ_BYTE: result = {{24{loadSign & b[0]}}, b};
      DSZ_HALF: result = {{16{loadSign & h[0]}}, h};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through, performs
// byte/half/word loads and stores over a req/ack port, and registers the
// write-back record. One access outstanding; upstream stalls while it is.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [0:31] aluResult,
  input  logic [0:31] storeData,
  input  logic [0:4]  destReg,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemWrite,
  input  logic        loadSign,
  input  logic [0:1]  DSize,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:3]  dmem_be,
  output logic [0:31] dmem_wdata,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [0:31] wb_data,
  output logic [0:4]  wb_destReg,
  output logic        wb_RegWrite,
  output logic        wb_misalign
);

  state_t      state_q;
  logic        we_q;
  logic [0:31] addr_q;
  logic [0:3]  be_q;
  logic [0:31] wdata_q;
  logic [0:1]  a_q;
  logic [0:1]  dsize_q;
  logic        lsign_q;
  logic [0:4]  dest_q;
  logic        rw_q;

  logic        wb_valid_q;
  logic [0:31] wb_data_q;
  logic [0:4]  wb_dest_q;
  logic        wb_rw_q;
  logic        wb_mis_q;

  logic        is_mem;
  logic        misalign;
  logic [0:1]  a;
  logic [0:3]  st_be;
  logic [0:31] st_wdata;
  logic [0:31] load_res;

  assign is_mem = MemToReg | MemWrite;
  assign a      = aluResult[30:31];

  // Store lane placement and alignment check on the incoming instruction.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = storeData;
    misalign = 1'b0;
    case (DSize)
      DSZ_BYTE: begin
        st_wdata = {4{storeData[24:31]}};
        st_be    = 4'b1000 >> a;
      end
      DSZ_HALF: begin
        st_wdata = {2{storeData[16:31]}};
        st_be    = a[0] ? 4'b0011 : 4'b1100;
        misalign = a[1];
      end
      default: misalign = |a;
    endcase
  end

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .a        (a_q),
    .DSize    (dsize_q),
    .loadSign (lsign_q),
    .result   (load_res)
  );

  // FSM plus access and write-back registers; wb_* fields pulse for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      a_q        <= '0;
      dsize_q    <= '0;
      lsign_q    <= 1'b0;
      dest_q     <= '0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      wb_rw_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= aluResult;
              wb_dest_q  <= destReg;
              wb_rw_q    <= RegWrite;
            end else if (misalign) begin
              // Faulting access: report it, never touch memory or the regfile.
              wb_valid_q <= 1'b1;
              wb_mis_q   <= 1'b1;
              wb_data_q  <= aluResult;
              wb_dest_q  <= destReg;
            end else begin
              state_q <= ACCESS;
              addr_q  <= {aluResult[0:29], 2'b00};
              we_q    <= MemWrite;
              be_q    <= MemWrite ? st_be : 4'b1111;
              wdata_q <= MemWrite ? st_wdata : '0;
              a_q     <= a;
              dsize_q <= DSize;
              lsign_q <= loadSign;
              dest_q  <= destReg;
              rw_q    <= RegWrite & ~MemWrite;
            end
          end
        end
        default: begin
          if (dmem_ack) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_data_q  <= we_q ? '0 : load_res;
            wb_dest_q  <= dest_q;
            wb_rw_q    <= rw_q;
          end
        end
      endcase
    end
  end

  // Stall and request decode only the registered state, never dmem_ack.
  assign stall       = (state_q == ACCESS);
  assign dmem_req    = (state_q == ACCESS);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_destReg  = wb_dest_q;
  assign wb_RegWrite = wb_rw_q;
  assign wb_misalign = wb_mis_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the ALU result (effective address or arithmetic result), store operand and control bits, and performs byte/half/word loads and stores over a req/ack data-memory port, stalling upstream while an access is outstanding. It registers the write-back value, destination register and write enable for the write-back stage. Vectors are big-endian, [0:31], with bit 0 as MSB and byte lane 0 = bits [0:7].

## Interface
Parameters: none. All widths fixed at 32-bit data/address, 5-bit register index.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- aluResult  in  [0:31]  address for loads/stores; result otherwise
- storeData  in  [0:31]  store operand (opB)
- destReg  in  [0:4]  destination register
- RegWrite, MemToReg, MemWrite, loadSign  in  1 each  control bits from decode
- DSize  in  [0:1]  00 byte, 01 half, 10 word, 11 treated as word
- stall  out  1  upstream must hold its outputs
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  [0:31]  word address, bits [30:31] forced 00
- dmem_be  out  [0:3]  byte enables, bit k = lane k
- dmem_wdata  out  [0:31]  lane-placed store data
- dmem_rdata  in  [0:31]  read data, valid with ack
- dmem_ack  in  1  access complete
- wb_valid  out  1  write-back record valid, one-cycle pulse per instruction
- wb_data  out  [0:31]  value to write back
- wb_destReg  out  [0:4]  write-back register
- wb_RegWrite  out  1  write enable, already qualified
- wb_misalign  out  1  pulses with wb_valid when the access was misaligned

## Operation
- States: IDLE, ACCESS. Reset → IDLE; all outputs 0.
- IDLE, ex_valid=0: nothing captured; wb_valid=0 next cycle.
- IDLE, ex_valid, neither MemToReg nor MemWrite: next cycle wb_valid=1, wb_data=aluResult, wb_RegWrite=RegWrite, wb_destReg=destReg.
- IDLE, ex_valid, memory op, aligned: latch address, control bits and lane-placed data; next state ACCESS.
- Alignment: half needs aluResult[31]=0; word needs [30:31]=00. Misaligned ops issue no memory request; next cycle wb_valid=1, wb_misalign=1, wb_RegWrite=0.
- ACCESS: dmem_req=1 with stable addr/we/be/wdata. On dmem_ack, capture result and go to IDLE; next cycle wb_valid=1.
- Store placement, a=aluResult[30:31]: byte → storeData[24:31] replicated to all lanes, be one-hot at lane a; half → storeData[16:31] in both halves, be=1100 if a[0]=0 else 0011; word → storeData, be=1111.
- Load extraction: byte → rdata lane a; half → rdata[0:15] if a[0]=0 else [16:31]; word → rdata. Sub-word result is sign-extended if loadSign=1, otherwise zero-extended.
- Store completion: wb_valid=1, wb_RegWrite=0.
- dmem_ack while in IDLE is ignored.

## Timing
- Non-memory and misaligned ops: 1-cycle latency, ex_valid at N → wb_valid at N+1.
- Memory ops: accepted at N, dmem_req high from N+1. Ack at N+k (k≥1) → wb_valid at N+k+1.
- stall = (state==ACCESS), registered-state decode with no combinational path from dmem_ack. It is high N+1..N+k, low at N+k+1, and the next instruction is accepted at N+k+1.
- One access outstanding; write-back order equals issue order.
- Reset asserted mid-ACCESS: dmem_req, stall and wb_valid drop immediately. The in-flight instruction is discarded, and a late ack is ignored.

## Structure
- Package mem_pkg: DSize encodings (DSZ_BYTE/HALF/WORD), state enum {IDLE, ACCESS}.
- Sub-module load_align: combinational lane extract plus sign/zero extension (inputs rdata, a, DSize, loadSign).
- Store lane placement and the FSM stay in mem_stage.

## Test plan
- ALU pass-through: ex_valid, aluResult=0x0000_1234, RegWrite=1, destReg=5 → next cycle wb_valid=1, wb_data=0x0000_1234, wb_destReg=5, stall never high.
- Signed byte load, addr 0x103, ack after 3 cycles, rdata=0x1122_3380 → dmem_addr=0x100, be=1111 (read), stall high 3 cycles, wb_data=0xFFFF_FF80. Repeat with loadSign=0 → 0x0000_0080.
- Half store, addr 0x202, storeData=0xAAAA_BEEF → dmem_we=1, be=0011, wdata=0xBEEF_BEEF, wb_valid with wb_RegWrite=0.
- Misaligned word load, addr 0x301 → no dmem_req, wb_misalign=1, wb_RegWrite=0 at N+1.
- Back-to-back: load (ack at first ACCESS cycle) followed by held ALU op → load written back at N+2, ALU op at N+3, order preserved.
- Reset pulsed while dmem_req high, then stray ack → outputs 0 at once, no wb_valid from the ack, FSM in IDLE.
